// File: rtl/lsu_wb.sv
// Load/store unit bridging RV32I load/store commands onto a simple request/acknowledge
// memory bus. One command is in flight at a time. Byte lanes are placed for stores and
// extracted and extended for loads. Misaligned or illegal commands, and bus timeouts,
// complete with a fault pulse.
module lsu_wb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr_in,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;

    // Counter value reached on the last REQ cycle allowed before aborting.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  eff_lo_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;

    logic [31:0] eff;
    logic        cmd_legal;
    logic        cmd_misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_shifted;
    logic [31:0] ld_data;

    assign eff  = base + offset;
    assign busy = (state_q != StIdle);

    // Decode legality and alignment of the command presented on the inputs.
    always_comb begin
        cmd_legal = 1'b0;
        if (is_store) begin
            cmd_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            cmd_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        cmd_misaligned = ((funct3[1:0] == 2'b01) && eff[0]) ||
                         ((funct3[1:0] == 2'b10) && (eff[1:0] != 2'b00));
    end

    // Byte strobes and lane-replicated write data for the incoming store.
    always_comb begin
        st_strb = 4'b1111;
        st_data = store_data;
        unique case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << eff[1:0];
                st_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << eff[1:0];
                st_data = {2{store_data[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = store_data;
            end
        endcase
    end

    // Select the addressed byte/halfword of the read word and extend it.
    always_comb begin
        ld_shifted = mem_rdata >> {eff_lo_q, 3'b000};
        ld_data    = mem_rdata;
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
            3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    // Control FSM; every bus and register-file output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            eff_lo_q   <= 2'b00;
            rd_q       <= 5'd0;
            cnt_q      <= 8'd0;
            done       <= 1'b0;
            fault      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'h0;
            mem_wdata  <= 32'h0;
            rd_we      <= 1'b0;
            rd_addr    <= 5'd0;
            rd_wdata   <= 32'h0;
        end else begin
            // Completion outputs are single-cycle pulses unless set below.
            done     <= 1'b0;
            fault    <= 1'b0;
            rd_we    <= 1'b0;
            rd_addr  <= 5'd0;
            rd_wdata <= 32'h0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        eff_lo_q   <= eff[1:0];
                        rd_q       <= rd_addr_in;
                        cnt_q      <= 8'd0;
                        if (!cmd_legal || cmd_misaligned) begin
                            state_q <= StErr;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                        end else begin
                            state_q   <= StReq;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {eff[31:2], 2'b00};
                            mem_wstrb <= is_store ? st_strb : 4'h0;
                            mem_wdata <= is_store ? st_data : 32'h0;
                        end
                    end
                end
                StReq: begin
                    if (mem_ack || (cnt_q == TimeoutLast)) begin
                        // An acknowledge on the final allowed cycle still completes normally.
                        state_q   <= mem_ack ? StResp : StErr;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_wstrb <= 4'h0;
                        mem_wdata <= 32'h0;
                        done      <= 1'b1;
                        fault     <= !mem_ack;
                        if (mem_ack && !is_store_q) begin
                            rd_we    <= (rd_q != 5'd0);
                            rd_addr  <= rd_q;
                            rd_wdata <= ld_data;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp, StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_wb.md
LSU_WB -- requirements
Module: lsu_wb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of REQ-state cycles without mem_ack before the access is aborted (legal range 2..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  command valid; sampled only in IDLE.
REQ-005 SHALL have port is_store  input  1  1 = store, 0 = load.
REQ-006 SHALL have port funct3  input  3  RV32I width/sign code.
REQ-007 SHALL have port base  input  32  rs1 value.
REQ-008 SHALL have port offset  input  32  sign-extended immediate.
REQ-009 SHALL have port store_data  input  32  rs2 value.
REQ-010 SHALL have port rd_addr_in  input  5  load destination register.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port fault  output  1  qualified by done: misaligned, illegal funct3 or timeout.
REQ-014 SHALL have ports mem_req/mem_we  output  1/1  bus request and write qualifier.
REQ-015 SHALL have ports mem_addr/mem_wstrb/mem_wdata  output  32/4/32  word-aligned address, byte strobes, lane-placed data.
REQ-016 SHALL have ports mem_ack/mem_rdata  input  1/32  bus completion and read word (valid with mem_ack).
REQ-017 SHALL have ports rd_we/rd_addr/rd_wdata  output  1/5/32  register-file write port.

Function
REQ-018 SHALL use a four-state FSM: IDLE, REQ, RESP, ERR.
REQ-019 SHALL, in IDLE with start=1, latch all command inputs and eff = base+offset (mod 2^32, carry discarded).
REQ-020 SHALL accept funct3 000/001/010/100/101 for loads and 000/001/010 for stores; any other code is illegal.
REQ-021 SHALL treat halfword with eff[0]=1, or word with eff[1:0]!=0, as misaligned.
REQ-022 SHALL go IDLE->ERR on an illegal or misaligned command, else IDLE->REQ.
REQ-023 SHALL hold mem_req=1 for every REQ cycle, with stable mem_addr={eff[31:2],2'b00}, mem_we, mem_wstrb and mem_wdata.
REQ-024 SHALL drive store strobes: SB 4'b0001<<eff[1:0]; SH 4'b0011<<eff[1:0]; SW 4'b1111; mem_wstrb=0 for loads.
REQ-025 SHALL replicate store data across lanes: byte x4, halfword x2, word as-is.
REQ-026 SHALL, on mem_ack=1 in REQ, capture mem_rdata, go to RESP, and drop mem_req on the following cycle.
REQ-027 SHALL count REQ cycles; the TIMEOUT-th cycle without mem_ack SHALL go to ERR; mem_ack on that same cycle wins (goes to RESP).
REQ-028 SHALL in RESP pulse done=1, fault=0 for one cycle and return to IDLE.
REQ-029 SHALL in RESP for a load assert rd_we=1 with rd_addr=latched rd_addr_in, unless that is 0 (rd_we=0).
REQ-030 SHALL extract load data by eff[1:0]: LB/LBU byte, LH/LHU halfword; sign-extend LB/LH, zero-extend LBU/LHU; LW full word.
REQ-031 SHALL in ERR pulse done=1, fault=1 for one cycle with rd_we=0, mem_req=0, and return to IDLE.
REQ-032 SHALL ignore start when not in IDLE, with no queuing.
REQ-033 SHALL keep rd_we, done and fault low outside RESP/ERR.
REQ-034 SHALL accept a start asserted in the same cycle as a done pulse only on the next IDLE cycle.

Reset
REQ-035 SHALL, on a clock edge with rst_n=0, enter IDLE and clear the counter and all latches; in any state, including mid-REQ, all outputs SHALL read 0 from that edge.
REQ-036 SHALL produce no done pulse and no rd_we for an access aborted by reset.

Verification
REQ-037 LB, base=0x100, offset=3, rd=5, mem_rdata=0x80FF_FFFF with ack at cycle 2 -> mem_addr=0x100; next cycle rd_we=1, rd_addr=5, rd_wdata=0xFFFF_FF80.
REQ-038 SH, base=0x200, offset=2, store_data=0x1234_ABCD -> mem_addr=0x200, wstrb=4'b1100, wdata=0xABCD_ABCD, mem_we=1; done one cycle after ack, rd_we=0.
REQ-039 LW with eff=0x102 -> no mem_req; done=1, fault=1 one cycle after start; rd_we=0.
REQ-040 LW with TIMEOUT=16 and ack never asserted -> mem_req high exactly 16 cycles, then done=1 and fault=1; ack on cycle 16 instead -> normal RESP.
REQ-041 start pulsed again during REQ -> ignored, exactly one done.
REQ-042 rst_n=0 during REQ -> mem_req=0 at that edge, no done, and an LBU from rd=0 afterwards completes with rd_we=0.
